sign_extend_arb: RTL and testbench
==================================

SIGN_EXTEND_ARB -- requirements
Module: sign_extend_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 The block SHALL have parameter BIT_WIDTH_IN, default 16: immediate width.
REQ-003 The block SHALL have parameter BIT_WIDTH_OUT, default 32: extended width, >= BIT_WIDTH_IN.
REQ-004 The block SHALL have parameter DELAY, default 1: extender pipeline latency in cycles, 0..4.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4: response FIFO entries, power of two, >= DELAY+1.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-008 The block SHALL have port req_valid, input, NUM_REQ: per-requester request valid.
REQ-009 The block SHALL have port req_ready, output, NUM_REQ: per-requester accept, at most one bit high.
REQ-010 The block SHALL have port req_data, input, NUM_REQ*BIT_WIDTH_IN: immediates; requester i in slice i.
REQ-011 The block SHALL have port req_signed, input, NUM_REQ: 1 = sign-extend, 0 = zero-extend, per requester.
REQ-012 The block SHALL have port rsp_valid, output, 1: response FIFO head valid.
REQ-013 The block SHALL have port rsp_ready, input, 1: consumer accepts head.
REQ-014 The block SHALL have port rsp_data, output, BIT_WIDTH_OUT: extended value at FIFO head.
REQ-015 The block SHALL have port rsp_id, output, clog2(NUM_REQ): requester index of the head.
REQ-016 The block SHALL have port busy, output, 1: high when in-flight count or FIFO count is non-zero.

Function
REQ-017 Credit: the block SHALL issue only when inflight + fifo_count < FIFO_DEPTH, using registered counts; a pop frees credit from the next cycle.
REQ-018 Arbitration SHALL be round-robin: the grant is the first requester with req_valid high, searching from pointer rr_ptr upward with wrap.
REQ-019 req_ready[g] SHALL be high combinationally only for the granted g, and only when credit is available and rst is low.
REQ-020 Issue occurs when req_valid[g] and req_ready[g] are both high; rr_ptr SHALL then become (g+1) mod NUM_REQ, and SHALL hold when there is no issue.
REQ-021 On issue, req_data slice g and req_signed[g] SHALL drive one extender lane (DEPTH=1); a tag {valid, id} SHALL travel a DELAY-stage shift register aligned with the data.
REQ-022 Extension SHALL be: signed -> upper BIT_WIDTH_OUT-BIT_WIDTH_IN bits copy input MSB; unsigned -> upper bits zero.
REQ-023 A valid tag leaving the pipe SHALL push {id, data} into the FIFO at the next edge; an issue at cycle t SHALL therefore give rsp_valid at t+DELAY+1 at the earliest.
REQ-024 Pop occurs on rsp_valid and rsp_ready; rsp_valid SHALL equal fifo_count != 0; responses SHALL leave in issue order.
REQ-025 Push and pop in the same cycle SHALL leave fifo_count unchanged; overflow is impossible by REQ-017, and an assertion SHALL flag it.
REQ-026 inflight SHALL increment on issue and decrement on tag exit; both together SHALL leave it unchanged.
REQ-027 With rsp_ready held high, the block SHALL sustain one issue per cycle.
REQ-028 The block SHALL have no internal state machine beyond rr_ptr, counters, tag pipe and FIFO; idle is busy=0.

Reset
REQ-029 While rst is high: rr_ptr=0, inflight=0, fifo_count=0, FIFO pointers=0, all tag valids=0, req_ready=0, rsp_valid=0, busy=0.
REQ-030 Reset mid-operation SHALL discard in-flight and queued responses; no rsp_valid SHALL appear for them after reset.

Structure
REQ-031 Package sign_extend_arb_pkg SHALL hold the ID-width and count-width functions and the tag struct type {valid, id}.
REQ-032 The existing sign_extend unit SHALL be instantiated as the datapath with DEPTH=1 and DELAY passed through.
REQ-033 The response FIFO SHALL be one sub-module, sign_extend_rsp_fifo, with synchronous active-high reset.

Verification
REQ-034 Signed: DELAY=1, req0 sends 16'h8001 with signed=1 at cycle t -> rsp_data=32'hFFFF8001, rsp_id=0, rsp_valid at t+2.
REQ-035 Unsigned: req1 sends 16'h8001 with signed=0 -> rsp_data=32'h00008001, rsp_id=1.
REQ-036 Fairness: all 4 req_valid held high, rsp_ready=1 -> issue order ids 0,1,2,3,0,1; one issue per cycle.
REQ-037 Backpressure: rsp_ready=0, all valid high -> exactly 4 issues, then req_ready=0; raise rsp_ready -> 4 responses in order, issuing resumes one cycle after first pop.
REQ-038 Skip: rr_ptr=0, only req2 valid -> req2 granted same cycle; rr_ptr becomes 3.
REQ-039 Reset mid-flight: 2 issued, rst high 1 cycle -> busy=0, no rsp_valid afterwards, next grant searches from req0.

Source files
------------

// File: rtl/sign_extend_arb_pkg.sv
// Shared sizing helpers and the tag type that follows each immediate
// through the extender pipeline of sign_extend_arb.
package sign_extend_arb_pkg;

   // Widest requester index ever needed (NUM_REQ <= 8).
   localparam int MAX_ID_W = 3;

   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/sign_extend.sv
// Multi-lane sign/zero extender with a configurable register pipeline
// (DELAY = 0 gives a purely combinational path).
module sign_extend #(
   parameter int DEPTH         = 1,
   parameter int BIT_WIDTH_IN  = 16,
   parameter int BIT_WIDTH_OUT = 32,
   parameter int DELAY         = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DEPTH*BIT_WIDTH_IN-1:0]    in_data,
   input  logic [DEPTH-1:0]                 in_signed,
   output logic [DEPTH*BIT_WIDTH_OUT-1:0]   out_data
);

   logic [DEPTH*BIT_WIDTH_OUT-1:0] ext_s;

   for (genvar l = 0; l < DEPTH; l++) begin : g_lane
      logic                     fill_s;
      logic [BIT_WIDTH_OUT-1:0] word_s;
      // Fill the upper bits with the MSB only for signed lanes.
      always_comb begin
         fill_s = in_signed[l] & in_data[l*BIT_WIDTH_IN + BIT_WIDTH_IN - 1];
         word_s = {BIT_WIDTH_OUT{fill_s}};
         word_s[BIT_WIDTH_IN-1:0] = in_data[l*BIT_WIDTH_IN +: BIT_WIDTH_IN];
      end
      assign ext_s[l*BIT_WIDTH_OUT +: BIT_WIDTH_OUT] = word_s;
   end

   if (DELAY == 0) begin : g_comb
      assign out_data = ext_s;
   end else begin : g_pipe
      logic [DEPTH*BIT_WIDTH_OUT-1:0] pipe_r [DELAY];
      // Shift the extended words through DELAY register stages.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DELAY; i++) pipe_r[i] <= '0;
         end else begin
            pipe_r[0] <= ext_s;
            for (int i = 1; i < DELAY; i++) pipe_r[i] <= pipe_r[i-1];
         end
      end
      assign out_data = pipe_r[DELAY-1];
   end

endmodule

// File: rtl/sign_extend_rsp_fifo.sv
// Response FIFO holding {id, data}; head is visible whenever count != 0.
module sign_extend_rsp_fifo
   import sign_extend_arb_pkg::*;
#(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head_data,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? AW'(0) : p + AW'(1);
   endfunction

   always_comb begin
      do_pop_s  = pop && (count_r != CW'(0));
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
   end

   // Pointers and occupancy; simultaneous push and pop leave count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
         if (do_pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= push_data;
   end

   assign head_data = mem_r[rd_ptr_r];
   assign count     = count_r;

   sign_extend_rsp_fifo_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (do_pop_s),
      .count (count_r)
   );

endmodule

// File: rtl/sign_extend_rsp_fifo_chk.sv
// Overflow checker for the response FIFO; credit control upstream must
// make a push into a full FIFO without a matching pop impossible.
module sign_extend_rsp_fifo_chk #(
   parameter int CW    = 3,
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);

   overflow_a : assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/sign_extend_arb.sv
// Round-robin, credit-controlled front end that shares one sign_extend
// lane among NUM_REQ requesters and returns results in issue order.
module sign_extend_arb
   import sign_extend_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int BIT_WIDTH_IN  = 16,
   parameter int BIT_WIDTH_OUT = 32,
   parameter int DELAY         = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*BIT_WIDTH_IN-1:0] req_data,
   input  logic [NUM_REQ-1:0]              req_signed,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [BIT_WIDTH_OUT-1:0]        rsp_data,
   output logic [id_width(NUM_REQ)-1:0]    rsp_id,
   output logic                            busy
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = cnt_width(FIFO_DEPTH);
   localparam int ENT_W = ID_W + BIT_WIDTH_OUT;

   logic [ID_W-1:0]          rr_ptr_r;
   logic [CNT_W-1:0]         inflight_r;
   logic [CNT_W-1:0]         fifo_count_s;
   logic [CNT_W:0]           used_s;
   logic                     credit_s;
   logic                     found_s;
   logic [ID_W-1:0]          grant_s;
   logic                     issue_s;
   logic [BIT_WIDTH_IN-1:0]  lane_data_s;
   logic                     lane_signed_s;
   logic [BIT_WIDTH_OUT-1:0] ext_data_s;
   logic [ENT_W-1:0]         head_s;
   tag_t                     tag_in_s;
   tag_t                     tag_out_s;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      grant_s = '0;
      found_s = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_s && req_valid[(int'(rr_ptr_r) + k) % NUM_REQ]) begin
            found_s = 1'b1;
            grant_s = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
         end else begin
            found_s = found_s;
         end
      end
   end

   always_comb begin
      used_s   = {1'b0, inflight_r} + {1'b0, fifo_count_s};
      credit_s = (used_s < (CNT_W+1)'(FIFO_DEPTH));
      req_ready = '0;
      if (!rst && credit_s && found_s) begin
         req_ready[grant_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
      issue_s       = |(req_valid & req_ready);
      lane_data_s   = req_data[int'(grant_s)*BIT_WIDTH_IN +: BIT_WIDTH_IN];
      lane_signed_s = req_signed[grant_s];
      tag_in_s.valid = issue_s;
      tag_in_s.id    = MAX_ID_W'(grant_s);
   end

   // Pointer advances past the granted requester; inflight tracks the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r   <= '0;
         inflight_r <= '0;
      end else begin
         if (issue_s) begin
            rr_ptr_r <= (grant_s == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : grant_s + ID_W'(1);
         end
         case ({issue_s, tag_out_s.valid})
            2'b10:   inflight_r <= inflight_r + CNT_W'(1);
            2'b01:   inflight_r <= inflight_r - CNT_W'(1);
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   if (DELAY == 0) begin : g_tag_comb
      assign tag_out_s = tag_in_s;
   end else begin : g_tag_pipe
      tag_t tag_r [DELAY];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < DELAY; i++) tag_r[i] <= '0;
         end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < DELAY; i++) tag_r[i] <= tag_r[i-1];
         end
      end
      assign tag_out_s = tag_r[DELAY-1];
   end

   sign_extend #(
      .DEPTH         (1),
      .BIT_WIDTH_IN  (BIT_WIDTH_IN),
      .BIT_WIDTH_OUT (BIT_WIDTH_OUT),
      .DELAY         (DELAY)
   ) u_ext (
      .clk       (clk),
      .rst       (rst),
      .in_data   (lane_data_s),
      .in_signed (lane_signed_s),
      .out_data  (ext_data_s)
   );

   sign_extend_rsp_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tag_out_s.valid),
      .push_data ({tag_out_s.id[ID_W-1:0], ext_data_s}),
      .pop       (rsp_valid && rsp_ready),
      .head_data (head_s),
      .count     (fifo_count_s)
   );

   assign rsp_valid = !rst && (fifo_count_s != CNT_W'(0));
   assign rsp_data  = head_s[BIT_WIDTH_OUT-1:0];
   assign rsp_id    = head_s[BIT_WIDTH_OUT +: ID_W];
   assign busy      = !rst && ((inflight_r != CNT_W'(0)) || (fifo_count_s != CNT_W'(0)));

endmodule

// File: tb/tb_sign_extend_arb.sv
// Directed plus randomized bench for sign_extend_arb against a queue-based
// model of arbitration, credit, extension and response ordering.
module tb_sign_extend_arb;

   localparam int NUM_REQ    = 4;
   localparam int DELAY      = 1;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_data;
   logic [3:0]  req_signed;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        busy;

   sign_extend_arb dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_signed (req_signed),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          avail;
   } rsp_t;

   rsp_t q[$];
   int   issue_log[$];
   int   m_ptr = 0;
   int   outstanding = 0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   fair_exp[6] = '{0, 1, 2, 3, 0, 1};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [15:0] d, input logic s);
      if (s && d >= 16'd32768) return 32'(d) + 32'hFFFF_0000;
      else                     return 32'(d);
   endfunction

   // One cycle: compare against the model, update it, advance to next negedge.
   task automatic tick();
      logic [3:0] exp_ready;
      bit         found;
      bit         exp_rv;
      int         g;
      int         idx;
      rsp_t       e;
      #1;
      exp_ready = 4'b0;
      found = 0;
      g = 0;
      if (!rst && outstanding < FIFO_DEPTH) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
               found = 1;
               g = idx;
            end
         end
      end
      if (found) exp_ready[g] = 1'b1;
      exp_rv = !rst && q.size() > 0 && q[0].avail <= cyc;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("busy", 64'(busy), 64'(!rst && outstanding != 0));
      if (exp_rv) begin
         check("rsp_data", 64'(rsp_data), 64'(q[0].data));
         check("rsp_id", 64'(rsp_id), 64'(q[0].id));
      end
      if (rst) begin
         q.delete();
         m_ptr = 0;
         outstanding = 0;
      end else begin
         if (found) begin
            e.id = g;
            e.data = ext(req_data[g*16 +: 16], req_signed[g]);
            e.avail = cyc + DELAY + 1;
            q.push_back(e);
            issue_log.push_back(g);
            m_ptr = (g + 1) % NUM_REQ;
            outstanding++;
         end
         if (exp_rv && rsp_ready) begin
            void'(q.pop_front());
            outstanding--;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 4'b0;
      req_data = 64'h0;
      req_signed = 4'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("idle_busy", 64'(busy), 64'h0);

      // Signed extension, response two cycles after issue
      req_data[15:0] = 16'h8001;
      req_signed = 4'b0001;
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0;
      tick();
      #1;
      check("signed_valid", 64'(rsp_valid), 64'h1);
      check("signed_data", 64'(rsp_data), 64'hFFFF_8001);
      check("signed_id", 64'(rsp_id), 64'h0);
      tick();

      // Unsigned extension from requester 1
      req_data[31:16] = 16'h8001;
      req_signed = 4'b0000;
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0;
      tick();
      #1;
      check("unsigned_data", 64'(rsp_data), 64'h0000_8001);
      check("unsigned_id", 64'(rsp_id), 64'h1);
      tick();

      // Skip to the only valid requester, then pointer sits at 3
      do_reset();
      req_valid = 4'b0100;
      #1;
      check("skip_grant", 64'(req_ready), 64'h4);
      tick();
      req_valid = 4'b1111;
      #1;
      check("skip_next", 64'(req_ready), 64'h8);
      tick();
      req_valid = 4'b0;
      repeat (4) tick();

      // Fairness with everyone requesting
      do_reset();
      issue_log.delete();
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      repeat (6) tick();
      check("fair_count", 64'(issue_log.size()), 64'd6);
      for (int i = 0; i < 6 && i < issue_log.size(); i++)
         check("fair_id", 64'(issue_log[i]), 64'(fair_exp[i]));
      req_valid = 4'b0;
      repeat (4) tick();

      // Backpressure fills credit, pop frees it one cycle later
      do_reset();
      issue_log.delete();
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      repeat (8) tick();
      check("bp_issues", 64'(issue_log.size()), 64'd4);
      check("bp_ready", 64'(req_ready), 64'h0);
      rsp_ready = 1'b1;
      tick();
      #1;
      check("bp_resume", 64'(req_ready), 64'h1);
      req_valid = 4'b0;
      repeat (8) tick();

      // Reset mid-flight discards everything
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'b0011;
      tick();
      tick();
      rst = 1'b1;
      req_valid = 4'b0;
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      repeat (4) tick();
      check("rst_busy", 64'(busy), 64'h0);
      req_valid = 4'b1111;
      #1;
      check("rst_grant", 64'(req_ready), 64'h1);
      tick();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         req_valid  = 4'($urandom);
         req_data   = {$urandom, $urandom};
         req_signed = 4'($urandom);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         rst        = ($urandom_range(0, 96) == 0);
         tick();
      end
      rst = 1'b0;
      req_valid = 4'b0;
      rsp_ready = 1'b1;
      repeat (10) tick();
      check("final_idle", 64'(busy), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
